// File: rtl/lsu_ctrl_pkg.sv
// ============================================================================
// lsu_ctrl_pkg : op, size and state encodings shared by the load/store unit
// Revision     : 1.0
// ============================================================================
`default_nettype none

package lsu_ctrl_pkg;

   typedef logic [3:0] oper_t;

   localparam oper_t OP_LB  = 4'd0;
   localparam oper_t OP_LH  = 4'd1;
   localparam oper_t OP_LW  = 4'd2;
   localparam oper_t OP_LBU = 4'd3;
   localparam oper_t OP_LHU = 4'd4;
   localparam oper_t OP_SB  = 4'd5;
   localparam oper_t OP_SH  = 4'd6;
   localparam oper_t OP_SW  = 4'd7;

   typedef logic [1:0] size_t;

   localparam size_t SZ_B = 2'd0;
   localparam size_t SZ_H = 2'd1;
   localparam size_t SZ_W = 2'd2;

   localparam logic [0:0] LSU_IDLE = 1'b0;
   localparam logic [0:0] LSU_BUSY = 1'b1;

   function automatic logic op_known(input oper_t op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
   endfunction

   function automatic logic op_is_store(input oper_t op);
      return op inside {OP_SB, OP_SH, OP_SW};
   endfunction

   function automatic size_t op_size(input oper_t op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return SZ_B;
         OP_LH, OP_LHU, OP_SH: return SZ_H;
         default:              return SZ_W;
      endcase
   endfunction

   function automatic logic is_aligned(input size_t sz, input logic [1:0] lo);
      case (sz)
         SZ_H:    return lo[0] == 1'b0;
         SZ_W:    return lo == 2'b00;
         default: return 1'b1;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ============================================================================
// lsu_load_align : selects the addressed lane of a read word and extends it
// Revision       : 1.0
// ============================================================================
`default_nettype none

module lsu_load_align
   import lsu_ctrl_pkg::*;
(
   input  oper_t       op,
   input  logic [1:0]  offset,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      case (op)
         OP_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
         OP_LBU:  data = {24'h0, shifted[7:0]};
         OP_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
         OP_LHU:  data = {16'h0, shifted[15:0]};
         default: data = shifted;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// lsu_ctrl : MEM-stage load/store sequencer with a single-outstanding bus
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int OPER_W = $bits(oper_t)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_valid,
   input  logic [OPER_W-1:0] mem_op,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   input  logic [4:0]        mem_rd,
   input  logic              flush,
   output logic              stall_req,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_data,
   output logic              misalign,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_sel,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata
);

   logic [0:0]        state_q, state_d;
   oper_t             op_q, op_d;
   logic [1:0]        off_q, off_d;
   logic [4:0]        rd_q, rd_d;
   logic              kill_q, kill_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [3:0]        bus_sel_q, bus_sel_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic              wb_valid_q, wb_valid_d;
   logic [4:0]        wb_rd_q, wb_rd_d;
   logic [31:0]       wb_data_q, wb_data_d;
   logic              misalign_q, misalign_d;

   oper_t             op_in;
   size_t             size_in;
   logic              accept, aligned, issue, reject;
   logic [31:0]       load_data;

   assign op_in   = oper_t'(mem_op);
   assign size_in = op_size(op_in);
   assign accept  = mem_valid && op_known(op_in) && !flush;
   assign aligned = is_aligned(size_in, mem_addr[1:0]);
   assign issue   = (state_q == LSU_IDLE) && accept && aligned;
   assign reject  = (state_q == LSU_IDLE) && accept && !aligned;

   lsu_load_align u_align (
      .op     (op_q),
      .offset (off_q),
      .rdata  (bus_rdata),
      .data   (load_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LSU_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LSU_IDLE: if (issue)   state_d = LSU_BUSY;
         LSU_BUSY: if (bus_ack) state_d = LSU_IDLE;
         default:               state_d = LSU_IDLE;
      endcase
   end

   // Released in the ack cycle so the pipeline advances on the writeback edge.
   always_comb begin
      stall_req = issue || ((state_q == LSU_BUSY) && !bus_ack);
   end

   always_comb begin
      op_d        = op_q;
      off_d       = off_q;
      rd_d        = rd_q;
      kill_d      = kill_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_sel_d   = bus_sel_q;
      bus_wdata_d = bus_wdata_q;
      wb_valid_d  = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      misalign_d  = reject;

      if (issue) begin
         op_d       = op_in;
         off_d      = mem_addr[1:0];
         rd_d       = mem_rd;
         kill_d     = 1'b0;
         bus_req_d  = 1'b1;
         bus_we_d   = op_is_store(op_in);
         bus_addr_d = {mem_addr[ADDR_W-1:2], 2'b00};
         case (size_in)
            SZ_B: begin
               bus_sel_d   = 4'b0001 << mem_addr[1:0];
               bus_wdata_d = {4{mem_wdata[7:0]}};
            end
            SZ_H: begin
               bus_sel_d   = 4'b0011 << mem_addr[1:0];
               bus_wdata_d = {2{mem_wdata[15:0]}};
            end
            default: begin
               bus_sel_d   = 4'b1111;
               bus_wdata_d = mem_wdata;
            end
         endcase
      end else if (state_q == LSU_BUSY) begin
         // A flush cannot cancel the bus cycle; it only drops the writeback.
         kill_d = kill_q || flush;
         if (bus_ack) begin
            bus_req_d = 1'b0;
            kill_d    = 1'b0;
            if (!op_is_store(op_q) && !kill_q && !flush) begin
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_data_d  = load_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q        <= OP_LB;
         off_q       <= 2'b00;
         rd_q        <= 5'd0;
         kill_q      <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_sel_q   <= 4'b0000;
         bus_wdata_q <= 32'h0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= 5'd0;
         wb_data_q   <= 32'h0;
         misalign_q  <= 1'b0;
      end else begin
         op_q        <= op_d;
         off_q       <= off_d;
         rd_q        <= rd_d;
         kill_q      <= kill_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_sel_q   <= bus_sel_d;
         bus_wdata_q <= bus_wdata_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         misalign_q  <= misalign_d;
      end
   end

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_sel   = bus_sel_q;
   assign bus_wdata = bus_wdata_q;
   assign wb_valid  = wb_valid_q;
   assign wb_rd     = wb_rd_q;
   assign wb_data   = wb_data_q;
   assign misalign  = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// tb_lsu_ctrl : directed and randomized checks of lsu_ctrl against a model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;
   import lsu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid;
   logic [3:0]  mem_op;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [4:0]  mem_rd;
   logic        flush;
   logic        stall_req, wb_valid, misalign, bus_req, bus_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_sel;
   logic        bus_ack;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   lsu_ctrl #(.ADDR_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_valid (mem_valid),
      .mem_op    (mem_op),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .flush     (flush),
      .stall_req (stall_req),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .misalign  (misalign),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_sel   (bus_sel),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: access size in bytes, from the opcode meaning.
   function automatic int nbytes(input logic [3:0] op);
      if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
      if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      int          n    = nbytes(op);
      logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      logic [31:0] v    = (rdata >> (8 * (addr % 4))) & mask;
      bit          sgn  = (op == OP_LB || op == OP_LH);
      if (sgn && v[8 * n - 1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [3:0] op, input logic [31:0] w);
      case (nbytes(op))
         1:       return (w & 32'hFF) * 32'h0101_0101;
         2:       return (w & 32'hFFFF) * 32'h0001_0001;
         default: return w;
      endcase
   endfunction

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_stall"},    stall_req, 0);
      check({pfx, "_wb_valid"}, wb_valid,  0);
      check({pfx, "_wb_rd"},    wb_rd,     0);
      check({pfx, "_wb_data"},  wb_data,   0);
      check({pfx, "_misalign"}, misalign,  0);
      check({pfx, "_bus_req"},  bus_req,   0);
      check({pfx, "_bus_we"},   bus_we,    0);
      check({pfx, "_bus_addr"}, bus_addr,  0);
      check({pfx, "_bus_sel"},  bus_sel,   0);
      check({pfx, "_bus_wd"},   bus_wdata, 0);
   endtask

   // flush_at: -1 none, -2 during the offer cycle, k>=0 during k-th busy cycle.
   task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input int delay, input logic [31:0] rdata,
                         input int flush_at);
      bit known    = (op <= 4'd7);
      bit is_store = (op >= 4'd5) && known;
      bit al       = (addr % nbytes(op)) == 0;
      bit taken    = known && (flush_at != -2);
      bit killed   = 1'b0;
      int stall_cycles = 0;
      @(negedge clk);
      mem_valid = 1'b1; mem_op = op; mem_addr = addr; mem_wdata = wdata; mem_rd = rd;
      flush = (flush_at == -2);
      #1;
      check("stall_offer", stall_req, taken && al);
      if (stall_req) stall_cycles++;
      if (!(taken && al)) begin
         @(negedge clk);
         mem_valid = 1'b0; flush = 1'b0;
         #1;
         check("misalign_pulse", misalign, taken && !al);
         check("nobus_req", bus_req, 0);
         check("nobus_stall", stall_req, 0);
         check("nobus_wb", wb_valid, 0);
         @(negedge clk);
         #1;
         check("misalign_drop", misalign, 0);
         return;
      end
      for (int k = 0; k <= delay; k++) begin
         @(negedge clk);
         mem_valid = 1'($urandom_range(0, 1));
         mem_op    = 4'($urandom_range(0, 7));
         mem_addr  = $urandom;
         flush     = (k == flush_at);
         if (flush) killed = 1'b1;
         bus_ack   = (k == delay);
         bus_rdata = (k == delay) ? rdata : $urandom;
         #1;
         check("busy_req",   bus_req,   1);
         check("busy_addr",  bus_addr,  addr & 32'hFFFF_FFFC);
         check("busy_sel",   bus_sel,   ((32'd1 << nbytes(op)) - 1) << (addr % 4));
         check("busy_we",    bus_we,    is_store);
         check("busy_wdata", bus_wdata, is_store ? model_wdata(op, wdata) : bus_wdata);
         check("busy_stall", stall_req, k != delay);
         if (stall_req) stall_cycles++;
      end
      check("stall_count", stall_cycles, delay + 1);
      @(negedge clk);
      bus_ack = 1'b0; mem_valid = 1'b0; flush = 1'b0;
      #1;
      check("done_req", bus_req, 0);
      check("done_wb_valid", wb_valid, !is_store && !killed);
      if (!is_store && !killed) begin
         check("done_wb_data", wb_data, model_load(op, addr, rdata));
         check("done_wb_rd",   wb_rd,   rd);
      end
      @(negedge clk);
      #1;
      check("wb_pulse_end", wb_valid, 0);
   endtask

   initial begin
      rst_n = 1'b0; mem_valid = 1'b0; mem_op = 4'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
      mem_rd = 5'd0; flush = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
      #7;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      access(OP_LW,  32'h100, 32'h0, 5'd7,  2, 32'hCAFE_F00D, -1);
      access(OP_LB,  32'h103, 32'h0, 5'd1,  0, 32'h80FF_1234, -1);
      access(OP_LBU, 32'h103, 32'h0, 5'd2,  1, 32'h80FF_1234, -1);
      access(OP_LH,  32'h102, 32'h0, 5'd3,  0, 32'h80FF_1234, -1);
      access(OP_SH,  32'h206, 32'hDEAD_BEEF, 5'd4, 1, 32'h0, -1);
      access(OP_LW,  32'h101, 32'h0, 5'd5,  0, 32'h0, -1);
      access(OP_SH,  32'h203, 32'h0, 5'd6,  0, 32'h0, -1);
      access(OP_LW,  32'h180, 32'h0, 5'd8,  3, 32'h1111_2222, 0);
      access(OP_LHU, 32'h182, 32'h0, 5'd9,  1, 32'h8765_4321, -1);

      // Ack while idle must not start anything.
      @(negedge clk);
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      check("idle_ack_req", bus_req, 0);
      check("idle_ack_wb",  wb_valid, 0);

      // Reset in the middle of an access.
      @(negedge clk);
      mem_valid = 1'b1; mem_op = OP_LW; mem_addr = 32'h300; mem_rd = 5'd12;
      @(negedge clk);
      mem_valid = 1'b0;
      #1;
      check("pre_rst_req", bus_req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      check("stale_ack_wb",  wb_valid, 0);
      check("stale_ack_req", bus_req, 0);
      check("stale_ack_stall", stall_req, 0);

      for (int i = 0; i < 60; i++) begin
         logic [3:0] op = 4'($urandom_range(0, 9));
         int d  = $urandom_range(0, 3);
         int r  = $urandom_range(0, 9);
         int fa = (r == 0) ? -2 : (r == 1) ? int'($urandom_range(0, d)) : -1;
         access(op, $urandom, $urandom, 5'($urandom), d, $urandom, fa);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencing controller for the MEM stage. Takes one decoded load or store op (LB/LH/LW/LBU/LHU/SB/SH/SW), a computed address and store data.
- Drives a single-outstanding req/ack data-bus handshake, stalls the pipeline while the access is in flight, then returns a sign/zero-extended load word with its destination register.
- Detects misaligned accesses and reports them without touching the bus.

Parameters:
- ADDR_W, 32, data-bus address width
- OPER_W, width of `oper_t, op field width (from shared defs)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  MEM stage holds a load/store op this cycle
- mem_op  in  OPER_W  decoded op (OP_LB..OP_LHU, OP_SB, OP_SH, OP_SW); any other value is ignored
- mem_addr  in  ADDR_W  effective byte address
- mem_wdata  in  32  store data (rs2 value)
- mem_rd  in  5  load destination register
- flush  in  1  discard the current op
- stall_req  out  1  pipeline stall request
- wb_valid  out  1  load result valid, one-cycle pulse
- wb_rd  out  5  load destination
- wb_data  out  32  extended load data
- misalign  out  1  one-cycle pulse on an accepted misaligned op
- bus_req  out  1  bus request
- bus_we  out  1  write enable
- bus_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- bus_sel  out  4  byte lanes
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completion; read data valid this cycle
- bus_rdata  in  32  read data

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0: stall_req, wb_valid, wb_rd, wb_data, misalign, bus_req, bus_we, bus_addr, bus_sel, bus_wdata.
  - Internal op, offset and rd latches cleared.
  - Reset mid-access abandons the access; no wb_valid is produced.
- State IDLE:
  - Accept when mem_valid && recognised op && !flush.
  - Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0.
  - If misaligned: pulse misalign the next cycle and stay in IDLE. No bus access and no wb_valid.
  - If aligned: register bus_addr={addr[ADDR_W-1:2],2'b00}, bus_sel, bus_we, bus_wdata, op, offset and rd; assert bus_req; go to BUSY.
- bus_sel:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- bus_wdata:
  - SB: {4{wdata[7:0]}}
  - SH: {2{wdata[15:0]}}
  - SW: wdata
- State BUSY:
  - bus_req and all bus_* outputs held stable until bus_ack.
  - On bus_ack: drop bus_req the same edge.
  - Load not flushed: register wb_data and wb_rd, and assert wb_valid for exactly one cycle (the cycle after ack). Go to IDLE.
  - Store: go to IDLE with no wb_valid.
- wb_data extraction: lane = offset from bus_rdata.
  - LB: sign-extend byte
  - LBU: zero-extend byte
  - LH: sign-extend half
  - LHU: zero-extend half
  - LW: full word
- stall_req (combinational): (IDLE && accept && aligned) || (BUSY && !bus_ack). Stall is released in the ack cycle, so the pipeline advances on the same edge wb_valid is registered.
- Latency: accept at edge N; bus_req visible N..N+k; ack at cycle N+k; wb_valid during cycle N+k+1. Minimum load-to-writeback is 2 cycles with a same-cycle ack.
- flush:
  - In IDLE: suppresses acceptance.
  - In BUSY: the bus transaction still completes (bus_req is never withdrawn before ack). A sticky kill bit suppresses wb_valid. A store already issued still commits.
- Simultaneous mem_valid in BUSY: ignored. Upstream is held by stall_req.
- bus_ack while IDLE: ignored.

Decomposition:
- Shared defs (cpu_defs): the new opcodes OP_SB, OP_SH, OP_SW; LSU state encodings (LSU_IDLE, LSU_BUSY); size encoding (SZ_B, SZ_H, SZ_W).
- One sub-module, lsu_load_align: combinational lane select plus sign/zero extension from (op, offset, rdata). Unit-testable alone.

Test Plan:
- LW at 0x100; bus acks 2 cycles after req. Expect:
  - bus_addr=0x100, sel=1111, we=0.
  - stall_req high 3 cycles.
  - wb_valid one cycle after ack with wb_data=bus_rdata and wb_rd=mem_rd.
- LB at 0x103 with rdata=0x80FF_1234. Expect sel=1000 and wb_data=0xFFFF_FF80. LBU at the same address returns 0x0000_0080. LH at 0x102 returns 0xFFFF_80FF.
- SH at 0x206 with wdata=0xDEAD_BEEF. Expect bus_addr=0x204, sel=1100, bus_wdata=0xBEEF_BEEF, we=1, and no wb_valid.
- LW at 0x101 (misaligned). Expect misalign pulse, bus_req stays 0, stall_req 0, wb_valid 0. SH at 0x203 gives the same result.
- Load issued, flush asserted in BUSY, ack arrives 3 cycles later. Expect bus_req held until ack, then no wb_valid; the next load proceeds normally.
- rst_n low while BUSY. Expect all outputs 0 immediately (async), state IDLE, and no wb_valid after rst_n releases even if a stale ack arrives.
